// File: rtl/prime_pkg.sv
// Shared definitions for the prime calculator: default widths, sequencer state
// codes and the display-path select values used by the top-level entry FSM.
package prime_pkg;

    localparam int DEF_N_WIDTH  = 20;
    localparam int DEF_D_WIDTH  = 11;
    localparam int DEF_SQ_WIDTH = 22;
    localparam int TESTS_WIDTH  = 10;

    // Sequencer states kept as plain codes so older netlists can decode them.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_TEST  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0] DISP_ENTRY  = 2'd0;
    localparam logic [1:0] DISP_CALC   = 2'd1;
    localparam logic [1:0] DISP_RESULT = 2'd2;

endpackage

// File: rtl/prime_trial_sequencer_if.sv
// Start/done handshake between the trial sequencer (master) and the shared
// iterative divider (slave).
interface prime_trial_sequencer_if #(
    parameter int N_WIDTH = prime_pkg::DEF_N_WIDTH,
    parameter int D_WIDTH = prime_pkg::DEF_D_WIDTH
) ();

    logic               div_start;
    logic [N_WIDTH-1:0] div_dividend;
    logic [D_WIDTH-1:0] div_divisor;
    logic               div_done;
    logic [D_WIDTH-1:0] div_remainder;

    modport master (
        output div_start,
        output div_dividend,
        output div_divisor,
        input  div_done,
        input  div_remainder
    );

    modport slave (
        input  div_start,
        input  div_dividend,
        input  div_divisor,
        output div_done,
        output div_remainder
    );

endinterface

// File: rtl/prime_trial_sequencer.sv
// Trial-division primality sequencer: walks odd divisors d=3,5,7.. through an
// external divider until a factor is found or d*d exceeds the candidate.
module prime_trial_sequencer
    import prime_pkg::*;
#(
    parameter int N_WIDTH  = DEF_N_WIDTH,
    parameter int D_WIDTH  = DEF_D_WIDTH,
    parameter int SQ_WIDTH = DEF_SQ_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [N_WIDTH-1:0]     value_i,
    prime_trial_sequencer_if.master div,
    output logic                   done_o,
    output logic                   is_prime_o,
    output logic [D_WIDTH-1:0]     factor_o,
    output logic [TESTS_WIDTH-1:0] tests_o
);

    logic [2:0]             state_q,  state_d;
    logic [N_WIDTH-1:0]     n_q,      n_d;
    logic [D_WIDTH-1:0]     trial_q,  trial_d;
    logic [SQ_WIDTH-1:0]    sq_q,     sq_d;
    logic [TESTS_WIDTH-1:0] tests_q,  tests_d;
    logic                   done_q,   done_d;
    logic                   prime_q,  prime_d;
    logic [D_WIDTH-1:0]     factor_q, factor_d;

    // sq tracks trial^2 incrementally: (d+2)^2 = d^2 + 4d + 4, so no multiplier.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        trial_d  = trial_q;
        sq_d     = sq_q;
        tests_d  = tests_q;
        prime_d  = prime_q;
        factor_d = factor_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d     = value_i;
                    tests_d = '0;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end else if (n_q < N_WIDTH'(2)) begin
                    prime_d  = 1'b0;
                    factor_d = '0;
                    state_d  = S_DONE;
                end else if (n_q == N_WIDTH'(2) || n_q == N_WIDTH'(3)) begin
                    prime_d  = 1'b1;
                    factor_d = '0;
                    state_d  = S_DONE;
                end else if (!n_q[0]) begin
                    prime_d  = 1'b0;
                    factor_d = D_WIDTH'(2);
                    state_d  = S_DONE;
                end else begin
                    trial_d = D_WIDTH'(3);
                    sq_d    = SQ_WIDTH'(9);
                    state_d = S_TEST;
                end
            end

            S_TEST: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end else if (sq_q > SQ_WIDTH'(n_q)) begin
                    prime_d  = 1'b1;
                    factor_d = '0;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                tests_d = tests_q + TESTS_WIDTH'(1);
                state_d = start_i ? S_WAIT : S_IDLE;
            end

            // An abort here must still swallow the outstanding divider result.
            S_WAIT: begin
                if (!start_i) begin
                    state_d = div.div_done ? S_IDLE : S_DRAIN;
                end else if (div.div_done) begin
                    if (div.div_remainder == '0) begin
                        prime_d  = 1'b0;
                        factor_d = trial_q;
                        state_d  = S_DONE;
                    end else begin
                        sq_d    = sq_q + (SQ_WIDTH'(trial_q) << 2) + SQ_WIDTH'(4);
                        trial_d = trial_q + D_WIDTH'(2);
                        state_d = S_TEST;
                    end
                end
            end

            S_DRAIN: begin
                if (div.div_done) begin
                    state_d = S_IDLE;
                end
            end

            S_DONE: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_IDLE) begin
            prime_d  = 1'b0;
            factor_d = '0;
        end
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            trial_q  <= '0;
            sq_q     <= '0;
            tests_q  <= '0;
            done_q   <= 1'b0;
            prime_q  <= 1'b0;
            factor_q <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            trial_q  <= trial_d;
            sq_q     <= sq_d;
            tests_q  <= tests_d;
            done_q   <= done_d;
            prime_q  <= prime_d;
            factor_q <= factor_d;
        end
    end

    assign div.div_start    = (state_q == S_ISSUE);
    assign div.div_dividend = n_q;
    assign div.div_divisor  = trial_q;

    assign done_o     = done_q;
    assign is_prime_o = prime_q;
    assign factor_o   = factor_q;
    assign tests_o    = tests_q;

endmodule

// File: tb/tb_prime_trial_sequencer.sv
// Scoreboard bench for prime_trial_sequencer with a variable-latency divider
// model; expected results and divisor sequences are queued per directed vector.
module tb_prime_trial_sequencer;
    import prime_pkg::*;

    localparam int NW = DEF_N_WIDTH;
    localparam int DW = DEF_D_WIDTH;

    typedef struct {
        int n;
        int lat;
        int prime;
        int factor;
        int tests;
    } vec_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] value = '0;
    logic          done;
    logic          isPrime;
    logic [DW-1:0] factor;
    logic [9:0]    tests;

    prime_trial_sequencer_if divIf ();

    prime_trial_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .value_i    (value),
        .div        (divIf),
        .done_o     (done),
        .is_prime_o (isPrime),
        .factor_o   (factor),
        .tests_o    (tests)
    );

    always #5 clk = ~clk;

    vec_t expQ[$];
    int   divisorQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   latency    = 1;
    int   divStarts  = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Divider model: answers lat cycles after each div_start and checks the divisor order.
    logic          busy = 1'b0;
    int            cnt  = 0;
    int            dvd  = 0;
    int            dvs  = 1;
    always @(negedge clk) begin
        divIf.div_done = 1'b0;
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                busy = 1'b0;
                divIf.div_done      = 1'b1;
                divIf.div_remainder = DW'(dvd % dvs);
            end
        end
        if (divIf.div_start) begin
            divStarts++;
            checkOutput("div_start_while_busy", busy, 0);
            if (divisorQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL div_start_unexpected: got divisor %0d, required no request", divIf.div_divisor);
            end else begin
                checkOutput("divisor", divIf.div_divisor, divisorQ.pop_front());
            end
            busy = 1'b1;
            cnt  = latency;
            dvd  = int'(divIf.div_dividend);
            dvs  = (divIf.div_divisor == '0) ? 1 : int'(divIf.div_divisor);
        end
    end

    // Result monitor: compares on every rising edge of done.
    logic donePrev = 1'b0;
    always @(negedge clk) begin
        if (done && !donePrev) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL done_unexpected: got done=1 with is_prime=%0d factor=%0d, required no result", isPrime, factor);
            end else begin
                vec_t e;
                e = expQ.pop_front();
                checkOutput($sformatf("is_prime N=%0d", e.n), isPrime, e.prime);
                checkOutput($sformatf("factor N=%0d", e.n), factor, e.factor);
                checkOutput($sformatf("tests N=%0d", e.n), tests, e.tests);
            end
        end
        donePrev = done;
    end

    task automatic applyStimulus(input int n, input int lat);
        @(negedge clk);
        latency = lat;
        value   = NW'(n);
        start   = 1'b1;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (!done && cycles < 6000) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("done_seen", done, 1);
    endtask

    task automatic releaseAndCheck();
        start = 1'b0;
        @(negedge clk);
        checkOutput("done_cleared", done, 0);
        checkOutput("is_prime_cleared", isPrime, 0);
        checkOutput("factor_cleared", factor, 0);
        @(negedge clk);
    endtask

    task automatic expectRun(input vec_t v);
        expQ.push_back(v);
        for (int k = 0; k < v.tests; k++) divisorQ.push_back(3 + 2 * k);
    endtask

    task automatic runVector(input vec_t v);
        int cycles;
        expectRun(v);
        applyStimulus(v.n, v.lat);
        waitDone(cycles);
        if (v.tests == 0) checkOutput($sformatf("latency N=%0d", v.n), cycles, 2);
        releaseAndCheck();
    endtask

    task automatic waitStarts(input int target, input string name);
        int guard = 0;
        while (divStarts < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(name, divStarts, target);
    endtask

    vec_t vecs[13] = '{
        '{0,       1, 0, 0, 0},
        '{1,       1, 0, 0, 0},
        '{2,       1, 1, 0, 0},
        '{3,       2, 1, 0, 0},
        '{4,       2, 0, 2, 0},
        '{1000,    3, 0, 2, 0},
        '{9,       3, 0, 3, 1},
        '{25,      4, 0, 5, 2},
        '{49,      6, 0, 7, 3},
        '{97,      1, 1, 0, 4},
        '{91,      7, 0, 7, 3},
        '{1048573, 2, 1, 0, 511},
        '{1048575, 8, 0, 3, 1}
    };

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   base;
        int   cycles;
        vec_t v;

        #3;
        checkOutput("rst_done", done, 0);
        checkOutput("rst_is_prime", isPrime, 0);
        checkOutput("rst_factor", factor, 0);
        checkOutput("rst_tests", tests, 0);
        checkOutput("rst_div_start", divIf.div_start, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) runVector(vecs[i]);

        // Abort mid-WAIT at test 100, then restart while the divider is still busy.
        base = divStarts;
        for (int k = 0; k < 100; k++) divisorQ.push_back(3 + 2 * k);
        applyStimulus(1048573, 5);
        waitStarts(base + 100, "abort_reach_test100");
        repeat (2) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("abort_tests", tests, 100);
        value = NW'(97);
        start = 1'b1;
        v = '{97, 5, 1, 0, 4};
        expectRun(v);
        waitDone(cycles);
        releaseAndCheck();

        // Asynchronous reset in the middle of a WAIT.
        base = divStarts;
        for (int k = 0; k < 3; k++) divisorQ.push_back(3 + 2 * k);
        applyStimulus(1048573, 5);
        waitStarts(base + 3, "reset_reach_test3");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_tests", tests, 0);
        checkOutput("async_rst_div_start", divIf.div_start, 0);
        checkOutput("async_rst_dividend", divIf.div_dividend, 0);
        checkOutput("async_rst_divisor", divIf.div_divisor, 0);
        checkOutput("async_rst_done", done, 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("late_done_ignored_done", done, 0);
        checkOutput("late_done_ignored_starts", divStarts, base + 3);
        checkOutput("late_done_ignored_tests", tests, 0);

        v = '{91, 4, 0, 7, 3};
        runVector(v);

        checkOutput("result_queue_drained", expQ.size(), 0);
        checkOutput("divisor_queue_drained", divisorQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/prime_trial_sequencer.md
Name: prime_trial_sequencer

Overview:
- Controller that sequences the trial-division primality test on the 20-bit value assembled by the top-level entry state machine.
- Enabled while the top-level FSM is in its Calculate state. Issues odd trial divisors to a shared iterative divider through a start/done handshake and tracks the running square of the divisor.
- Raises done, which drives the top-level CountBlockDone input, and presents the prime/factor result to the display path.

Parameters:
- N_WIDTH, 20, width of the candidate value.
- D_WIDTH, 11, width of the trial divisor. Must satisfy 2^(D_WIDTH-1) >= sqrt(2^N_WIDTH).
- SQ_WIDTH, 22, width of the running divisor-square register. Must be >= 2*D_WIDTH.

Ports:
- clk  in  1  system clock.
- Reset  in  1  asynchronous active-low reset.
- start  in  1  level; high while the top-level FSM is in Calculate.
- value  in  N_WIDTH  candidate N; sampled only on the IDLE->CHECK transition.
- div_start  out  1  one-cycle pulse requesting a division.
- div_dividend  out  N_WIDTH  registered copy of N.
- div_divisor  out  D_WIDTH  current trial divisor d.
- div_done  in  1  one-cycle pulse from the divider; remainder valid in the same cycle.
- div_remainder  in  D_WIDTH  N mod d.
- done  out  1  result valid; held high in DONE.
- is_prime  out  1  valid when done=1.
- factor  out  D_WIDTH  smallest factor found; 0 if prime or N<2.
- tests  out  10  number of divisions issued.

Behaviour:
- Async reset: state=IDLE; all outputs 0; internal N, d and sq registers cleared.
- States: IDLE, CHECK, TEST, ISSUE, WAIT, DRAIN, DONE.
- IDLE:
  - On start=1, capture value into N, clear tests, go to CHECK.
  - Outputs done, is_prime, factor are cleared on entry to IDLE.
- CHECK (one cycle):
  - N<2: is_prime=0, factor=0, go to DONE.
  - N==2 or N==3: is_prime=1, go to DONE.
  - N even: is_prime=0, factor=2, go to DONE.
  - Otherwise: d=3, sq=9, go to TEST.
- TEST:
  - sq>N: is_prime=1, factor=0, go to DONE.
  - Else go to ISSUE.
- ISSUE: assert div_start for exactly one cycle, tests+=1, go to WAIT.
- WAIT:
  - On div_done with remainder==0: is_prime=0, factor=d, go to DONE.
  - On div_done with remainder!=0: sq <= sq + 4*d + 4 (equal to (d+2)^2), then d <= d+2, go to TEST.
  - Arithmetic on sq is SQ_WIDTH unsigned with no overflow: max d=1025, so max sq=1050625.
- DONE:
  - done=1; result outputs frozen.
  - On start=0, go to IDLE with done=0 on the following cycle.
- Abort, start=0 before DONE:
  - From CHECK, TEST or ISSUE: go to IDLE next cycle. An ISSUE pulse already in progress completes.
  - From WAIT: go to DRAIN. DRAIN waits for div_done, discards the result, then goes to IDLE. No div_start is issued while in DRAIN.
- div_done outside WAIT/DRAIN is ignored.
- Changes on value after capture are ignored.
- Minimum latency: start sampled at cycle 0 -> CHECK at cycle 1 -> done=1 at cycle 2 for small/even cases.
- One division costs 2 cycles plus divider latency, plus 1 TEST cycle.

Decomposition:
- Shared package prime_pkg holds:
  - state enum codes;
  - N_WIDTH/D_WIDTH/SQ_WIDTH defaults;
  - DISP_* select constants (0 entry, 1 calculating, 2 result) reused by the top-level FSM.
- No sub-module: the divider is external and shared, and this block owns only sequencing.

Test Plan:
Bench uses a divider model with a configurable latency of 1-8 cycles.
- N=0 and N=1, start held -> done at cycle 2, is_prime=0, factor=0, tests=0; no div_start seen.
- N=2, N=3 -> is_prime=1, tests=0. N=1000 -> is_prime=0, factor=2, tests=0.
- N=97 -> divisors 3,5,7,9 issued in order, tests=4, is_prime=1, factor=0. N=91 -> divisors 3,5,7, factor=7, tests=3.
- N=1048573 (largest 20-bit prime) -> divisors 3..1023, tests=511, is_prime=1, no sq overflow. N=1048575 -> factor=3, tests=1.
- Abort: N=1048573, drop start while in WAIT at test 100 with divider latency 5 -> DRAIN until div_done, then IDLE. done never asserted, no further div_start. A restart with N=97 then gives tests=4.
- Reset asserted mid-WAIT -> all outputs 0 immediately (async). A late div_done after release is ignored; a new start behaves normally.
